rs232_avalon_slave: RTL
=======================

# rs232_avalon_slave

Avalon-MM slave modelling the RS232 UART register map that the RSA256 wrapper polls as a bus master. It sits at the other end of that master's `avm_*` interface, in simulation and on the FPGA, in place of the vendor UART core. Host bytes come in on a valid/ready stream and are queued for the master to read. Bytes the master writes are queued and emitted on a second valid/ready stream.

## Interface
- `DEPTH`, 16: entries per byte FIFO; power of two, ≥2.
- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `avs_address`  in  5  byte address: 0 = RXDATA, 4 = TXDATA, 8 = STATUS.
- `avs_read`  in  1  read request; held by master until waitrequest low.
- `avs_write`  in  1  write request; held by master until waitrequest low.
- `avs_writedata`  in  32  write data; bits [7:0] used.
- `avs_readdata`  out  32  registered read data; valid while waitrequest low.
- `avs_waitrequest`  out  1  high = access not yet accepted.
- `i_rx_data`  in  8  host→master byte.
- `i_rx_valid`  in  1  rx byte valid.
- `o_rx_ready`  out  1  `!rx_full`.
- `o_tx_data`  out  8  master→host byte, head of the TX FIFO.
- `o_tx_valid`  out  1  `!tx_empty`.
- `i_tx_ready`  in  1  host accepts the tx byte.

## Operation
- The bus FSM has two states, IDLE and ACK.
- IDLE: `avs_waitrequest` = 1.
  - On `avs_read` or `avs_write`, move to ACK, latch `avs_readdata`, and perform the side effect on the same edge.
  - If `avs_read` and `avs_write` are both high, the read wins and the write is ignored.
- ACK: `avs_waitrequest` = 0 for exactly one cycle, then return to IDLE unconditionally.
- Every access therefore takes 2 cycles. Back-to-back accesses also take 2 cycles each.
- RXDATA read:
  - `readdata` = {24'0, head byte} and the RX FIFO pops.
  - If the RX FIFO is empty: `readdata` = 0 and no pop.
- TXDATA write:
  - Pushes `writedata[7:0]`.
  - If the TX FIFO is full: the byte is dropped and sticky TOE is set.
- STATUS read: `readdata` = {23'0, TOE, RRDY, TRDY, 6'0}.
  - TOE = bit 8.
  - RRDY = bit 7 = `!rx_empty`.
  - TRDY = bit 6 = `!tx_full`.
- STATUS write (any data): clears TOE.
- Reads of TXDATA or an unmapped address return 0. Writes to RXDATA or an unmapped address have no effect.
- RX stream: push when `i_rx_valid && o_rx_ready`.
- TX stream: pop when `o_tx_valid && i_tx_ready`.
- FIFO push and pop may occur in the same cycle.
  - When full, ready is low, so no push occurs even if a pop happens that cycle.
  - When empty, a bus pop is suppressed even if a stream push happens that cycle.
- Occupancy counters are `$clog2(DEPTH)+1` bits wide. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.

## Timing
- Reset values:
  - `avs_waitrequest` = 1, `avs_readdata` = 0, FSM = IDLE.
  - Both FIFOs empty, so `o_rx_ready` = 1, `o_tx_valid` = 0, `o_tx_data` = 0.
  - TOE = 0.
- Bus latency: request seen at edge N; `waitrequest` is low and `readdata` is valid in cycle N+1.
- Register values are snapshotted at edge N, before that edge's stream push or pop.
- A byte pushed on the RX stream at edge N is visible to a STATUS read sampled at edge N+1 or later.
- A TXDATA write accepted at edge N gives `o_tx_valid` = 1 in cycle N+1, provided the FIFO was empty.
- Reset asserted mid-access: the FSM returns to IDLE, FIFO contents are discarded, and the master's pending access is lost.

## Configuration
- `RS232_SLAVE_STALL_EN`:
  - Defined: in IDLE, an RXDATA read with the RX FIFO empty, or a TXDATA write with the TX FIFO full, keeps `waitrequest` high. The FSM advances once the condition clears, so nothing is dropped. TOE is never set and reads as 0.
  - Undefined: the drop/zero behaviour above applies.

## Structure
- Package `rs232_pkg` holds:
  - address localparams `RX_BASE` = 0, `TX_BASE` = 4, `STATUS_BASE` = 8;
  - status bit indices `RRDY_BIT` = 7, `TRDY_BIT` = 6, `TOE_BIT` = 8;
  - FSM enum `bus_state_e` {S_IDLE, S_ACK}.
- Sub-module `byte_fifo` (parameter DEPTH; ports `i_clk`, `i_rst_n`, push/data/pop, full/empty, head data) is instantiated twice, once for RX and once for TX.

## Test plan
- Reset with no traffic: STATUS read returns 0x40; `waitrequest` is low exactly one cycle after the request; `o_tx_valid` = 0.
- Stream 0xA5 then 0x3C on the RX port:
  - STATUS reads return 0xC0.
  - Two RXDATA reads return 0xA5 then 0x3C.
  - A third RXDATA read returns 0, and STATUS then returns 0x40.
- Write 0x11 to TXDATA with `i_tx_ready` = 0: `o_tx_valid` = 1 and `o_tx_data` = 0x11 from the cycle after acceptance. Raising `i_tx_ready` pops the byte and drops `o_tx_valid`.
- TX overrun (macro undefined):
  - Write DEPTH+1 bytes with `i_tx_ready` = 0; STATUS returns 0x100.
  - The host receives only the first DEPTH bytes.
  - A STATUS write then clears TOE, and STATUS returns 0x000 (TX full, RX empty).
- Same overrun with `RS232_SLAVE_STALL_EN` defined: `waitrequest` stays high on write DEPTH+1 until `i_tx_ready` pulses once; all DEPTH+1 bytes are delivered in order.
- Fill the RX FIFO until `o_rx_ready` = 0, then drive an RX push and an RXDATA read at the same edge: the push is refused, exactly one byte pops, and `o_rx_ready` returns to 1 the next cycle.

Source files
------------

// File: rtl/rs232_avalon_slave_pkg.sv
// ============================================================================
// Module   : rs232_pkg
// Brief    : Shared register map, status bit positions and bus FSM encoding
//            for rs232_avalon_slave (optional RS232_SLAVE_STALL_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RRDY_BIT = 7;
  localparam int TRDY_BIT = 6;
  localparam int TOE_BIT  = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] status_word(input logic toe,
                                              input logic rrdy,
                                              input logic trdy);
    logic [31:0] w;
    w           = '0;
    w[TOE_BIT]  = toe;
    w[RRDY_BIT] = rrdy;
    w[TRDY_BIT] = trdy;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs232_avalon_slave_byte_fifo.sv
// ============================================================================
// Module   : byte_fifo
// Brief    : Synchronous byte FIFO, power-of-two depth, push/pop guarded
//            internally against full/empty; head reads 0 while empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rs232_avalon_slave.sv
// ============================================================================
// Module   : rs232_avalon_slave
// Brief    : Avalon-MM slave exposing an RS232-style RXDATA/TXDATA/STATUS map
//            over two byte FIFOs. Define RS232_SLAVE_STALL_EN to stall instead
//            of dropping on RX-empty reads and TX-full writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_avalon_slave
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  bus_state_e  state_q;
  logic [31:0] readdata_q;
  logic        waitreq_q;
  logic        toe_q;
  logic        toe_d;

  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_head;
  logic        rx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic [7:0]  tx_head;
  logic        tx_push;

  logic        is_rx;
  logic        is_tx;
  logic        is_st;
  logic        req_rd;
  logic        req_wr;
  logic        stall;
  logic        accept;
  logic [31:0] rd_data;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata[31:8];

  assign is_rx  = (avs_address == RX_BASE);
  assign is_tx  = (avs_address == TX_BASE);
  assign is_st  = (avs_address == STATUS_BASE);
  assign req_rd = avs_read;
  assign req_wr = avs_write && !avs_read;

`ifdef RS232_SLAVE_STALL_EN
  assign stall = (req_rd && is_rx && rx_empty) || (req_wr && is_tx && tx_full);
`else
  assign stall = 1'b0;
`endif

  assign accept  = (state_q == S_IDLE) && (req_rd || req_wr) && !stall;
  assign rx_pop  = accept && req_rd && is_rx && !rx_empty;
  assign tx_push = accept && req_wr && is_tx && !tx_full;

  always_comb begin
    toe_d = toe_q;
`ifndef RS232_SLAVE_STALL_EN
    if (accept && req_wr && is_st) begin
      toe_d = 1'b0;
    end else if (accept && req_wr && is_tx && tx_full) begin
      toe_d = 1'b1;
    end
`endif
  end

  // Snapshot of the register map taken before this edge's stream traffic.
  always_comb begin
    rd_data = '0;
    if (req_rd) begin
      if (is_rx && !rx_empty) begin
        rd_data = {24'h0, rx_head};
      end else if (is_st) begin
        rd_data = status_word(toe_q, !rx_empty, !tx_full);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      waitreq_q  <= 1'b1;
      readdata_q <= '0;
      toe_q      <= 1'b0;
    end else begin
      toe_q <= toe_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q    <= S_ACK;
            waitreq_q  <= 1'b0;
            readdata_q <= rd_data;
          end
        end
        S_ACK: begin
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
      endcase
    end
  end

  assign avs_readdata    = readdata_q;
  assign avs_waitrequest = waitreq_q;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_i  (i_rx_valid && !rx_full),
    .data_i  (i_rx_data),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_i  (tx_push),
    .data_i  (avs_writedata[7:0]),
    .pop_i   (i_tx_ready && !tx_empty),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  assign o_rx_ready = !rx_full;
  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_head;

endmodule

`default_nettype wire
